// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared definitions for the pipelined control unit.
//   Opcode localparams (6-bit MIPS-style primary opcodes), ALU-op codes,
//   and ctrl_bundle_t, the decoded control bundle for one instruction.
// Optional feature macro: CPU_CTRL_IMM_EN (enables addi/andi/ori decode).
package cpu_ctrl_pkg;

  localparam int BASE_OP_W    = 6;
  localparam int BASE_ALUOP_W = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] aluop;
  } ctrl_bundle_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode -- purely combinational opcode -> ctrl_bundle_t table.
// Ports:
//   valid     in   instruction valid; invalid decodes to the all-zero NOP
//   opcode    in   OPCODE_W primary opcode (OPCODE_W >= 6; upper bits must be 0)
//   ctrl      out  decoded control bundle
//   rt_is_src out  instruction reads rt as a source operand (hazard check)
// Optional feature macro: CPU_CTRL_IMM_EN adds addi/andi/ori; otherwise NOP.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                valid,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        ctrl,
  output logic                rt_is_src
);

  logic [5:0] op6;
  logic       upper_zero;

  // Opcodes wider than the base table only match when the extra bits are 0.
  generate
    if (OPCODE_W > BASE_OP_W) begin : g_wide
      assign op6        = opcode[5:0];
      assign upper_zero = ~|opcode[OPCODE_W-1:BASE_OP_W];
    end else begin : g_exact
      assign op6        = opcode;
      assign upper_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    ctrl      = '0;
    rt_is_src = 1'b0;
    if (valid && upper_zero) begin
      case (op6)
        OP_RTYPE: begin
          ctrl.regdst   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALU_FUNCT;
          rt_is_src     = 1'b1;
        end
        OP_J: ctrl.jump = 1'b1;
        OP_LW: begin
          ctrl.alusrc   = 1'b1;
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.memread  = 1'b1;
          ctrl.aluop    = ALU_ADD;
        end
        OP_SW: begin
          ctrl.alusrc   = 1'b1;
          ctrl.memwrite = 1'b1;
          ctrl.aluop    = ALU_ADD;
          rt_is_src     = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.aluop  = ALU_SUB;
          rt_is_src   = 1'b1;
        end
`ifdef CPU_CTRL_IMM_EN
        // Immediate ALU ops write rt, so rt is a destination, not a source.
        OP_ADDI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALU_ADD;
        end
        OP_ANDI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALU_AND;
        end
        OP_ORI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALU_OR;
        end
`endif
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_pipe.sv
// cpu_ctrl_pipe -- pipelined control unit: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, load-use hazard detection, flush handling and a
// saturating bubble counter.
// Ports:
//   clk, rst (async, active-high)
//   id_valid, id_opcode, id_rs, id_rt   ID-stage instruction
//   flush                               kill younger instructions
//   id_jump                             combinational jump decode (0 on flush)
//   ex_aluop, ex_regdst, ex_alusrc      ID/EX outputs
//   mem_memread, mem_memwrite, mem_branch  EX/MEM outputs
//   wb_regwrite, wb_memtoreg            MEM/WB outputs
//   load_use_stall                      hold PC and IF/ID this cycle
//   bubble_cnt                          saturating count of inserted bubbles
// Optional feature macro: CPU_CTRL_IMM_EN (immediate ALU ops in decode).
module cpu_ctrl_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                flush,
  output logic                id_jump,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                mem_branch,
  output logic                wb_regwrite,
  output logic                wb_memtoreg,
  output logic                load_use_stall,
  output logic [CNT_W-1:0]    bubble_cnt
);

  ctrl_bundle_t id_ctrl;
  logic         id_rt_is_src;
  logic         id_bubble;

  // ID/EX
  logic       ex_valid_reg, ex_regdst_reg, ex_alusrc_reg, ex_memtoreg_reg;
  logic       ex_regwrite_reg, ex_memread_reg, ex_memwrite_reg, ex_branch_reg;
  logic [2:0] ex_aluop_reg;
  logic [4:0] ex_rt_reg;
  // EX/MEM
  logic mem_valid_reg, mem_memread_reg, mem_memwrite_reg, mem_branch_reg;
  logic mem_regwrite_reg, mem_memtoreg_reg;
  // MEM/WB
  logic wb_valid_reg, wb_regwrite_reg, wb_memtoreg_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  cpu_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .valid     (id_valid),
    .opcode    (id_opcode),
    .ctrl      (id_ctrl),
    .rt_is_src (id_rt_is_src)
  );

  // flush overrides the stall: the younger instruction is being killed anyway.
  assign load_use_stall = id_valid & ex_valid_reg & ex_memread_reg &
                          (ex_rt_reg != 5'd0) &
                          ((ex_rt_reg == id_rs) | ((ex_rt_reg == id_rt) & id_rt_is_src)) &
                          ~flush;
  assign id_bubble = flush | load_use_stall;
  assign id_jump   = id_ctrl.jump & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_regdst_reg    <= 1'b0;
      ex_alusrc_reg    <= 1'b0;
      ex_memtoreg_reg  <= 1'b0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      ex_memwrite_reg  <= 1'b0;
      ex_branch_reg    <= 1'b0;
      ex_aluop_reg     <= '0;
      ex_rt_reg        <= '0;
      mem_valid_reg    <= 1'b0;
      mem_memread_reg  <= 1'b0;
      mem_memwrite_reg <= 1'b0;
      mem_branch_reg   <= 1'b0;
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      wb_valid_reg     <= 1'b0;
      wb_regwrite_reg  <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      bubble_cnt_reg   <= '0;
    end else begin
      // ID/EX: a bubble is an invalid, all-zero stage.
      if (id_bubble || !id_valid) begin
        ex_valid_reg    <= 1'b0;
        ex_regdst_reg   <= 1'b0;
        ex_alusrc_reg   <= 1'b0;
        ex_memtoreg_reg <= 1'b0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
        ex_memwrite_reg <= 1'b0;
        ex_branch_reg   <= 1'b0;
        ex_aluop_reg    <= '0;
        ex_rt_reg       <= '0;
      end else begin
        ex_valid_reg    <= 1'b1;
        ex_regdst_reg   <= id_ctrl.regdst;
        ex_alusrc_reg   <= id_ctrl.alusrc;
        ex_memtoreg_reg <= id_ctrl.memtoreg;
        ex_regwrite_reg <= id_ctrl.regwrite;
        ex_memread_reg  <= id_ctrl.memread;
        ex_memwrite_reg <= id_ctrl.memwrite;
        ex_branch_reg   <= id_ctrl.branch;
        ex_aluop_reg    <= id_ctrl.aluop;
        ex_rt_reg       <= id_rt;
      end

      // EX/MEM: only flush kills it; a stall lets EX drain normally.
      mem_valid_reg    <= ex_valid_reg & ~flush;
      mem_memread_reg  <= ex_memread_reg & ~flush;
      mem_memwrite_reg <= ex_memwrite_reg & ~flush;
      mem_branch_reg   <= ex_branch_reg & ~flush;
      mem_regwrite_reg <= ex_regwrite_reg & ~flush;
      mem_memtoreg_reg <= ex_memtoreg_reg & ~flush;

      // MEM/WB always advances.
      wb_valid_reg    <= mem_valid_reg;
      wb_regwrite_reg <= mem_regwrite_reg;
      wb_memtoreg_reg <= mem_memtoreg_reg;

      if (id_bubble && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign ex_aluop     = ex_valid_reg ? ALUOP_W'(ex_aluop_reg) : '0;
  assign ex_regdst    = ex_valid_reg & ex_regdst_reg;
  assign ex_alusrc    = ex_valid_reg & ex_alusrc_reg;
  assign mem_memread  = mem_valid_reg & mem_memread_reg;
  assign mem_memwrite = mem_valid_reg & mem_memwrite_reg;
  assign mem_branch   = mem_valid_reg & mem_branch_reg;
  assign wb_regwrite  = wb_valid_reg & wb_regwrite_reg;
  assign wb_memtoreg  = wb_valid_reg & wb_memtoreg_reg;
  assign bubble_cnt   = bubble_cnt_reg;

endmodule

// File: tb/tb_cpu_ctrl_pipe.sv
// tb_cpu_ctrl_pipe -- directed self-checking bench for cpu_ctrl_pipe.
// Uses CNT_W=4 so bubble_cnt saturation is reachable quickly.
// Optional feature macro: CPU_CTRL_IMM_EN changes the expected addi decode.
module tb_cpu_ctrl_pipe;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 3;
  localparam int CNT_W    = 4;

  localparam logic [5:0] R_OP   = 6'b000000;
  localparam logic [5:0] J_OP   = 6'b000010;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] ADDI_OP= 6'b001000;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;
  localparam logic [5:0] BAD_OP = 6'b111111;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                flush;
  logic                id_jump;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic                ex_regdst;
  logic                ex_alusrc;
  logic                mem_memread;
  logic                mem_memwrite;
  logic                mem_branch;
  logic                wb_regwrite;
  logic                wb_memtoreg;
  logic                load_use_stall;
  logic [CNT_W-1:0]    bubble_cnt;

  int errors = 0;
  int checks = 0;

  cpu_ctrl_pipe #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .flush          (flush),
    .id_jump        (id_jump),
    .ex_aluop       (ex_aluop),
    .ex_regdst      (ex_regdst),
    .ex_alusrc      (ex_alusrc),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_branch     (mem_branch),
    .wb_regwrite    (wb_regwrite),
    .wb_memtoreg    (wb_memtoreg),
    .load_use_stall (load_use_stall),
    .bubble_cnt     (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    flush     = fl;
    #1;
    $display("t=%0t issue v=%0b op=%06b rs=%0d rt=%0d flush=%0b stall=%0b jump=%0b",
             $time, v, op, rs, rt, fl, load_use_stall, id_jump);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_aluop"},  32'(ex_aluop), 0);
    chk({tag, "_ex_regdst"}, 32'(ex_regdst), 0);
    chk({tag, "_ex_alusrc"}, 32'(ex_alusrc), 0);
    chk({tag, "_mem_rd"},    32'(mem_memread), 0);
    chk({tag, "_mem_wr"},    32'(mem_memwrite), 0);
    chk({tag, "_mem_br"},    32'(mem_branch), 0);
    chk({tag, "_wb_rw"},     32'(wb_regwrite), 0);
    chk({tag, "_wb_m2r"},    32'(wb_memtoreg), 0);
    chk({tag, "_stall"},     32'(load_use_stall), 0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
    #2;
    chk_all_zero("reset");
    chk("reset_cnt", 32'(bubble_cnt), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_stall", 32'(load_use_stall), 0);
    chk("post_reset_cnt", 32'(bubble_cnt), 0);

    // Load-use on rs: one stall cycle, one bubble.
    issue(1, LW_OP, 5'd0, 5'd5, 0);
    chk("lw_nostall", 32'(load_use_stall), 0);
    tick();
    chk("lw_ex_alusrc", 32'(ex_alusrc), 1);
    chk("lw_ex_aluop", 32'(ex_aluop), 0);
    issue(1, R_OP, 5'd5, 5'd7, 0);
    chk("lu_stall", 32'(load_use_stall), 1);
    tick();
    chk("lu_bubble_regdst", 32'(ex_regdst), 0);
    chk("lu_bubble_alusrc", 32'(ex_alusrc), 0);
    chk("lu_mem_memread", 32'(mem_memread), 1);
    chk("lu_cnt", 32'(bubble_cnt), 1);
    chk("lu_stall_released", 32'(load_use_stall), 0);
    tick();
    chk("r_ex_regdst", 32'(ex_regdst), 1);
    chk("r_ex_aluop", 32'(ex_aluop), 2);
    chk("lw_wb_regwrite", 32'(wb_regwrite), 1);
    chk("lw_wb_memtoreg", 32'(wb_memtoreg), 1);
    chk("lu_cnt_hold", 32'(bubble_cnt), 1);

    // rt=0 load never stalls.
    issue(1, LW_OP, 5'd1, 5'd0, 0);
    tick();
    issue(1, R_OP, 5'd0, 5'd0, 0);
    chk("rt0_nostall", 32'(load_use_stall), 0);
    tick();
    chk("rt0_ex_regdst", 32'(ex_regdst), 1);
    chk("rt0_cnt", 32'(bubble_cnt), 1);

    // sw reads rt: stall.
    issue(1, LW_OP, 5'd1, 5'd5, 0);
    tick();
    issue(1, SW_OP, 5'd1, 5'd5, 0);
    chk("sw_stall", 32'(load_use_stall), 1);
    tick();
    chk("sw_cnt", 32'(bubble_cnt), 2);
    chk("sw_stall_released", 32'(load_use_stall), 0);
    tick();
    chk("sw_ex_alusrc", 32'(ex_alusrc), 1);

    // addi does not read rt: no stall either way.
    issue(1, LW_OP, 5'd1, 5'd5, 0);
    tick();
    issue(1, ADDI_OP, 5'd1, 5'd5, 0);
    chk("addi_nostall", 32'(load_use_stall), 0);
    tick();
`ifdef CPU_CTRL_IMM_EN
    chk("addi_ex_alusrc", 32'(ex_alusrc), 1);
`else
    chk("addi_ex_alusrc", 32'(ex_alusrc), 0);
`endif
    chk("addi_ex_aluop", 32'(ex_aluop), 0);
    chk("addi_cnt", 32'(bubble_cnt), 2);

    // Stall and flush together: flush wins, both ID/EX and EX/MEM bubble.
    issue(1, LW_OP, 5'd1, 5'd5, 0);
    tick();
    issue(1, R_OP, 5'd5, 5'd7, 1);
    chk("sf_stall", 32'(load_use_stall), 0);
    tick();
    chk("sf_ex_regdst", 32'(ex_regdst), 0);
    chk("sf_mem_memread", 32'(mem_memread), 0);
    chk("sf_cnt", 32'(bubble_cnt), 3);
    issue(0, R_OP, 5'd0, 5'd0, 0);
    tick();
    chk("sf_wb_regwrite", 32'(wb_regwrite), 0);
    tick();
    tick();

    // Stream sw, beq, j, 111111.
    issue(1, SW_OP, 5'd2, 5'd3, 0);
    chk("str_jump_sw", 32'(id_jump), 0);
    tick();
    issue(1, BEQ_OP, 5'd2, 5'd3, 0);
    tick();
    chk("str_mem_memwrite", 32'(mem_memwrite), 1);
    chk("str_mem_branch0", 32'(mem_branch), 0);
    issue(1, J_OP, 5'd0, 5'd0, 0);
    chk("str_jump", 32'(id_jump), 1);
    tick();
    chk("str_mem_branch", 32'(mem_branch), 1);
    chk("str_mem_memwrite0", 32'(mem_memwrite), 0);
    issue(1, BAD_OP, 5'd9, 5'd9, 0);
    chk("str_jump_off", 32'(id_jump), 0);
    tick();
    chk("bad_ex_aluop", 32'(ex_aluop), 0);
    chk("bad_ex_regdst", 32'(ex_regdst), 0);
    chk("bad_ex_alusrc", 32'(ex_alusrc), 0);
    issue(0, R_OP, 5'd0, 5'd0, 0);
    tick();
    chk("bad_mem_rd", 32'(mem_memread), 0);
    chk("bad_mem_wr", 32'(mem_memwrite), 0);
    chk("bad_mem_br", 32'(mem_branch), 0);

    // Jump suppressed during flush; flush alone still counts a bubble.
    issue(1, J_OP, 5'd0, 5'd0, 1);
    chk("jump_flush", 32'(id_jump), 0);
    tick();
    chk("jump_flush_cnt", 32'(bubble_cnt), 4);

    // Asynchronous reset mid-stream.
    issue(1, LW_OP, 5'd1, 5'd3, 0);
    tick();
    issue(1, R_OP, 5'd1, 5'd2, 0);
    tick();
    chk("pre_rst_ex_regdst", 32'(ex_regdst), 1);
    chk("pre_rst_mem_memread", 32'(mem_memread), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cnt", 32'(bubble_cnt), 0);
    issue(0, R_OP, 5'd0, 5'd0, 0);
    rst = 1'b0;
    tick();

    // Saturation at all-ones.
    issue(0, R_OP, 5'd0, 5'd0, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_reach", 32'(bubble_cnt), 15);
    tick();
    tick();
    chk("sat_hold", 32'(bubble_cnt), 15);
    issue(0, R_OP, 5'd0, 5'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_pipe.md
CPU_CTRL_PIPE -- requirements
Module: cpu_ctrl_pipe

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6: instruction opcode width.
REQ-002 SHALL have parameter ALUOP_W, default 3: ALU-op code width, minimum 3.
REQ-003 SHALL have parameter CNT_W, default 16: width of the bubble counter.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port id_valid  in  1: ID-stage instruction valid.
REQ-007 SHALL have port id_opcode  in  OPCODE_W: ID-stage opcode.
REQ-008 SHALL have port id_rs  in  5: ID-stage source register rs.
REQ-009 SHALL have port id_rt  in  5: ID-stage register rt.
REQ-010 SHALL have port flush  in  1: taken branch or jump; kill younger instructions.
REQ-011 SHALL have port id_jump  out  1: combinational, decoded jump from ID.
REQ-012 SHALL have port ex_aluop  out  ALUOP_W: ID/EX register output.
REQ-013 SHALL have ports ex_regdst, ex_alusrc  out  1 each: ID/EX register outputs.
REQ-014 SHALL have ports mem_memread, mem_memwrite, mem_branch  out  1 each: EX/MEM register outputs.
REQ-015 SHALL have ports wb_regwrite, wb_memtoreg  out  1 each: MEM/WB register outputs.
REQ-016 SHALL have port load_use_stall  out  1: combinational request to hold PC and IF/ID.
REQ-017 SHALL have port bubble_cnt  out  CNT_W: saturating count of inserted bubbles.

Function
REQ-018 Decode SHALL map R-type 000000 to regdst, regwrite, aluop 010.
REQ-019 Decode SHALL map j 000010 to jump only.
REQ-020 Decode SHALL map lw 100011 to alusrc, memtoreg, regwrite, memread, with aluop 000.
REQ-021 Decode SHALL map sw 101011 to alusrc, memwrite, with aluop 000.
REQ-022 Decode SHALL map beq 000100 to branch, aluop 001.
REQ-023 Decode SHALL map any other opcode, and id_valid=0, to the all-zero bundle (NOP).
REQ-024 Pipeline latency SHALL be: opcode decoded at edge N appears on ex_* after N+1, mem_* after N+2, wb_* after N+3.
REQ-025 Each stage SHALL carry a valid bit; all outputs of an invalid stage SHALL be 0.
REQ-026 ID/EX SHALL also hold rt and memread internally for hazard detection.
REQ-027 load_use_stall SHALL equal id_valid & ID/EX memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt & opcode in {R-type, sw, beq})) & ~flush.
REQ-028 On stall, ID/EX SHALL load a bubble; EX/MEM and MEM/WB SHALL advance normally.
REQ-029 On flush, ID/EX and EX/MEM SHALL load bubbles at the next edge; MEM/WB SHALL advance.
REQ-030 flush SHALL take priority over stall when both are asserted in the same cycle.
REQ-031 id_jump SHALL be 0 while flush is asserted.
REQ-032 bubble_cnt SHALL increment by 1 per edge on which ID/EX loads a bubble due to stall or flush, and SHALL saturate at all-ones.

Reset
REQ-033 rst SHALL clear all stage valids and control bits, and bubble_cnt, to 0 immediately, independent of clk.
REQ-034 The first valid instruction after rst deassertion SHALL follow REQ-024 timing.
REQ-035 No stall SHALL be raised in the cycle after reset.

Configuration
REQ-036 With CPU_CTRL_IMM_EN defined, decode SHALL add addi 001000 (alusrc, regwrite, aluop 000), andi 001100 (alusrc, regwrite, aluop 011) and ori 001101 (alusrc, regwrite, aluop 100).
REQ-037 With CPU_CTRL_IMM_EN defined, these opcodes SHALL NOT use rt as a source in REQ-027.
REQ-038 Without CPU_CTRL_IMM_EN, those opcodes SHALL decode to NOP.

Structure
REQ-039 Package cpu_ctrl_pkg SHALL hold the opcode localparams, ALU-op code constants, and the ctrl_bundle_t packed struct.
REQ-040 Sub-module cpu_ctrl_decode SHALL hold the purely combinational opcode-to-ctrl_bundle_t table, including the CPU_CTRL_IMM_EN branch.
REQ-041 cpu_ctrl_pipe SHALL instantiate cpu_ctrl_decode and implement the registers, hazard logic and counter.

Verification
REQ-042 lw $t rt=5 then R-type rs=5 back-to-back -> load_use_stall=1 for one cycle, one bubble reaches ex_*, bubble_cnt=1.
REQ-043 lw rt=0 then R-type rs=0 -> no stall.
REQ-044 lw rt=5 then sw rt=5 -> stall; lw rt=5 then addi rt=5 with IMM_EN -> no stall.
REQ-045 Stall and flush in the same cycle -> load_use_stall=0, ID/EX and EX/MEM bubble, bubble_cnt increments by 1.
REQ-046 Stream sw, beq, j, opcode 111111 -> mem_memwrite=1 at N+2, mem_branch=1 at N+3, id_jump=1 at N+2 only, all-zero bundle for 111111.
REQ-047 rst asserted mid-stream between edges -> all outputs 0 immediately; force bubble_cnt near all-ones -> holds at all-ones.
